wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage of the 5-stage RV32 core; sits directly downstream of the memory stage.
//  Holds one instruction in a pipeline register loaded via valid/ready handshake.
//  Commits it: register-file write, CSR file update, retire counter, difftest retire pulse.
//  Freezes the core on ebreak.
// PARAMETERS
//  XLEN         32            datapath width
//  CNT_W        64            width of minstret retire counter
//  EBREAK_INST  32'h00100073  encoding that halts the core
//  MSTATUS_RST  32'h00001800  reset value of mstatus (MPP=M)
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     synchronous reset, active-low
//  valid_last    in   1     memory stage has an instruction
//  ready_last    out  1     wb_stage can accept (combinational)
//  pc            in   XLEN  instruction PC
//  inst          in   32    instruction word
//  R_wen         in   1     instruction writes rd
//  rd            in   5     destination register
//  mem_ren       in   1     instruction is a load
//  MEM_Rdata     in   XLEN  load data, already extended
//  Ex_result     in   XLEN  ALU/CSR-read result
//  csr_wen       in   4     [0]mstatus [1]mtvec [2]mepc [3]mcause
//  csrs          in   XLEN  CSR write value
//  jump_flag     in   1     instruction redirected fetch (trace only)
//  commit_stall  in   1     external hold (difftest/debug)
//  rf_wen        out  1     regfile write enable
//  rf_waddr      out  5     regfile write address
//  rf_wdata      out  XLEN  regfile write data
//  mstatus, mtvec, mepc, mcause  out  XLEN each  CSR file contents
//  retire_valid  out  1     one-cycle pulse per committed instruction
//  retire_pc     out  XLEN  PC of retiring instruction
//  retire_inst   out  32    instruction word of retiring instruction
//  retire_jump   out  1     jump_flag of retiring instruction
//  minstret      out  CNT_W committed-instruction count
//  halt          out  1     core halted by ebreak
// BEHAVIOUR
//  Pipeline register:
//  - On valid_last & ready_last at posedge, latch all inputs and set v_reg = 1.
//  - Else, if commit, clear v_reg.
//  - commit = v_reg & !commit_stall & state==RUN.
//  - ready_last = (state==RUN) & (!v_reg | !commit_stall), so accept and commit can
//    happen in the same cycle (full throughput).
//  Write-back:
//  - wdata = mem_ren_reg ? MEM_Rdata_reg : Ex_result_reg.
//  - rf_wen = commit & R_wen_reg & (rd_reg != 0); x0 is never written.
//  - rf_waddr = rd_reg; rf_wdata = wdata, driven combinationally.
//  - Regfile samples them at the next posedge (1-cycle latency from capture).
//  CSR file:
//  - On commit, each set bit of csr_wen_reg loads csrs_reg into its CSR at posedge.
//  - Multiple bits set load the same value into all selected CSRs.
//  Retire:
//  - retire_valid = commit; retire_pc, retire_inst and retire_jump come from the registers.
//  - minstret += 1 on commit and wraps at 2^CNT_W-1 -> 0.
//  FSM: RUN -> HALT when commit & inst_reg == EBREAK_INST.
//  - The ebreak itself retires and is counted; it performs no rf write.
//  - HALT is sticky until reset: halt = 1, ready_last = 0, no further commits.
//  commit_stall high with v_reg = 1: hold all state, no writes, no retire pulse.
//  - Captured data must stay stable until the stall drops.
//  Reset:
//  - v_reg = 0, state = RUN, halt = 0, retire_valid = 0, rf_wen = 0, minstret = 0.
//  - mstatus = MSTATUS_RST; mtvec = mepc = mcause = 0; all latched fields = 0.
//  - ready_last = 1 during the cycle after reset.
//  - Reset mid-stall or mid-HALT discards the held instruction without committing it.
// TESTING
//  1. Capture addi pc=0x80000000 rd=5 Ex_result=0x1234, R_wen=1.
//     -> next cycle rf_wen=1 waddr=5 wdata=0x1234, retire_valid=1, minstret=1.
//  2. Load with mem_ren=1, MEM_Rdata=0xFFFFFF80, Ex_result=0x80001000.
//     -> wdata=0xFFFFFF80; same op with rd=0 -> rf_wen=0 but retire_valid=1.
//  3. valid_last held high for 4 back-to-back ops, commit_stall=0.
//     -> 4 consecutive retire pulses, ready_last constantly 1, minstret=4.
//  4. commit_stall=1 for 3 cycles with v_reg=1.
//     -> ready_last=0, no rf_wen/retire for 3 cycles, commit on first cycle stall=0.
//  5. csr_wen=4'b0100, csrs=0x80000010.
//     -> mepc=0x80000010, other CSRs unchanged; mstatus reads 0x1800 after reset.
//  6. Retire inst=0x00100073 followed by another valid op.
//     -> retire_valid=1, halt=1 next cycle, ready_last=0 forever.
//     -> rst_n=0 for one cycle restores RUN with minstret=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction from the memory stage, then commits its
// regfile write, CSR updates and retire trace. Halts the core on ebreak.
module wb_stage #(
    parameter int               XLEN        = 32,
    parameter int               CNT_W       = 64,
    parameter logic [31:0]      EBREAK_INST = 32'h00100073,
    parameter logic [XLEN-1:0]  MSTATUS_RST = 32'h00001800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_last,
    output logic             ready_last,
    input  logic [XLEN-1:0]  pc,
    input  logic [31:0]      inst,
    input  logic             R_wen,
    input  logic [4:0]       rd,
    input  logic             mem_ren,
    input  logic [XLEN-1:0]  MEM_Rdata,
    input  logic [XLEN-1:0]  Ex_result,
    input  logic [3:0]       csr_wen,
    input  logic [XLEN-1:0]  csrs,
    input  logic             jump_flag,
    input  logic             commit_stall,
    output logic             rf_wen,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic [XLEN-1:0]  mstatus,
    output logic [XLEN-1:0]  mtvec,
    output logic [XLEN-1:0]  mepc,
    output logic [XLEN-1:0]  mcause,
    output logic             retire_valid,
    output logic [XLEN-1:0]  retire_pc,
    output logic [31:0]      retire_inst,
    output logic             retire_jump,
    output logic [CNT_W-1:0] minstret,
    output logic             halt
);

    typedef enum logic {RUN, HALT} state_t;

    state_t state, state_next;

    logic            v_reg;
    logic [XLEN-1:0] pc_reg;
    logic [31:0]     inst_reg;
    logic            r_wen_reg;
    logic [4:0]      rd_reg;
    logic            mem_ren_reg;
    logic [XLEN-1:0] mem_rdata_reg;
    logic [XLEN-1:0] ex_result_reg;
    logic [3:0]      csr_wen_reg;
    logic [XLEN-1:0] csrs_reg;
    logic            jump_reg;

    logic accept;
    logic commit;
    logic is_ebreak;

    // Reset is folded into commit so a held instruction is dropped, never retired.
    assign commit     = rst_n & v_reg & ~commit_stall & (state == RUN);
    assign ready_last = (state == RUN) & (~v_reg | ~commit_stall);
    assign accept     = valid_last & ready_last;
    assign is_ebreak  = (inst_reg == EBREAK_INST);

    assign rf_wen       = commit & r_wen_reg & (rd_reg != 5'd0) & ~is_ebreak;
    assign rf_waddr     = rd_reg;
    assign rf_wdata     = mem_ren_reg ? mem_rdata_reg : ex_result_reg;
    assign retire_valid = commit;
    assign retire_pc    = pc_reg;
    assign retire_inst  = inst_reg;
    assign retire_jump  = jump_reg;
    assign halt         = (state == HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_reg         <= 1'b0;
            pc_reg        <= '0;
            inst_reg      <= '0;
            r_wen_reg     <= 1'b0;
            rd_reg        <= '0;
            mem_ren_reg   <= 1'b0;
            mem_rdata_reg <= '0;
            ex_result_reg <= '0;
            csr_wen_reg   <= '0;
            csrs_reg      <= '0;
            jump_reg      <= 1'b0;
        end else if (accept) begin
            v_reg         <= 1'b1;
            pc_reg        <= pc;
            inst_reg      <= inst;
            r_wen_reg     <= R_wen;
            rd_reg        <= rd;
            mem_ren_reg   <= mem_ren;
            mem_rdata_reg <= MEM_Rdata;
            ex_result_reg <= Ex_result;
            csr_wen_reg   <= csr_wen;
            csrs_reg      <= csrs;
            jump_reg      <= jump_flag;
        end else if (commit) begin
            v_reg <= 1'b0;
        end
    end

    // Several enable bits may be set at once; all selected CSRs take the same value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus <= MSTATUS_RST;
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (commit) begin
            if (csr_wen_reg[0]) mstatus <= csrs_reg;
            if (csr_wen_reg[1]) mtvec   <= csrs_reg;
            if (csr_wen_reg[2]) mepc    <= csrs_reg;
            if (csr_wen_reg[3]) mcause  <= csrs_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            minstret <= '0;
        end else if (commit) begin
            minstret <= minstret + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // HALT is sticky; only reset leaves it.
    always_comb begin
        state_next = state;
        if (commit && is_ebreak) begin
            state_next = HALT;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven vectors feed a retire scoreboard,
// plus hand-written sequences for stall, ebreak halt and reset corner cases.
module tb_wb_stage;

    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_last;
    logic        ready_last;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        R_wen;
    logic [4:0]  rd;
    logic        mem_ren;
    logic [31:0] MEM_Rdata;
    logic [31:0] Ex_result;
    logic [3:0]  csr_wen;
    logic [31:0] csrs;
    logic        jump_flag;
    logic        commit_stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_inst;
    logic        retire_jump;
    logic [63:0] minstret;
    logic        halt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .valid_last(valid_last), .ready_last(ready_last),
        .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
        .MEM_Rdata(MEM_Rdata), .Ex_result(Ex_result), .csr_wen(csr_wen), .csrs(csrs),
        .jump_flag(jump_flag), .commit_stall(commit_stall), .rf_wen(rf_wen),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .mstatus(mstatus), .mtvec(mtvec),
        .mepc(mepc), .mcause(mcause), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_inst(retire_inst), .retire_jump(retire_jump), .minstret(minstret),
        .halt(halt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        r_wen;
        logic [4:0]  rd;
        logic        mem_ren;
        logic [31:0] mdata;
        logic [31:0] ex;
        logic [3:0]  csr_wen;
        logic [31:0] csrs;
        logic        jump;
        logic        exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        cur;
    vec_t        exp_q[$];
    vec_t        tbl[8];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] model_cnt;
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    bit          model_halt;

    function automatic vec_t mkVec(input logic [31:0] p, input logic [31:0] i, input logic rw,
                                   input logic [4:0] r, input logic mr, input logic [31:0] md,
                                   input logic [31:0] ex, input logic [3:0] cw,
                                   input logic [31:0] cv, input logic j, input logic ew,
                                   input logic [31:0] ed);
        vec_t v;
        v.pc = p; v.inst = i; v.r_wen = rw; v.rd = r; v.mem_ren = mr; v.mdata = md;
        v.ex = ex; v.csr_wen = cw; v.csrs = cv; v.jump = j; v.exp_wen = ew; v.exp_wdata = ed;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cur        = v;
        pc         = v.pc;
        inst       = v.inst;
        R_wen      = v.r_wen;
        rd         = v.rd;
        mem_ren    = v.mem_ren;
        MEM_Rdata  = v.mdata;
        Ex_result  = v.ex;
        csr_wen    = v.csr_wen;
        csrs       = v.csrs;
        jump_flag  = v.jump;
        valid_last = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checkOutput(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: retires are matched in order against captured vectors; the
    // CSR, counter and halt models advance only on a matched retire.
    always @(negedge clk) begin : monitor
        vec_t e;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt  = '0;
            m_mstatus  = 32'h00001800;
            m_mtvec    = '0;
            m_mepc     = '0;
            m_mcause   = '0;
            model_halt = 1'b0;
        end else begin
            checkOutput("minstret", minstret, model_cnt);
            checkOutput("mstatus", 64'(mstatus), 64'(m_mstatus));
            checkOutput("mtvec", 64'(mtvec), 64'(m_mtvec));
            checkOutput("mepc", 64'(mepc), 64'(m_mepc));
            checkOutput("mcause", 64'(mcause), 64'(m_mcause));
            checkOutput("halt", 64'(halt), 64'(model_halt));
            if (retire_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_retire", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("retire_pc", 64'(retire_pc), 64'(e.pc));
                    checkOutput("retire_inst", 64'(retire_inst), 64'(e.inst));
                    checkOutput("retire_jump", 64'(retire_jump), 64'(e.jump));
                    checkOutput("rf_wen", 64'(rf_wen), 64'(e.exp_wen));
                    if (e.exp_wen) begin
                        checkOutput("rf_waddr", 64'(rf_waddr), 64'(e.rd));
                        checkOutput("rf_wdata", 64'(rf_wdata), 64'(e.exp_wdata));
                    end
                    model_cnt = model_cnt + 64'd1;
                    if (e.csr_wen[0]) m_mstatus = e.csrs;
                    if (e.csr_wen[1]) m_mtvec   = e.csrs;
                    if (e.csr_wen[2]) m_mepc    = e.csrs;
                    if (e.csr_wen[3]) m_mcause  = e.csrs;
                    if (e.inst == EBREAK) model_halt = 1'b1;
                end
            end else begin
                checkOutput("idle_rf_wen", 64'(rf_wen), 64'd0);
            end
            if (valid_last && ready_last && !model_halt) exp_q.push_back(cur);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t s;
        vec_t f;
        rst_n        = 1'b0;
        valid_last   = 1'b0;
        commit_stall = 1'b0;
        applyStimulus(mkVec('0, '0, 0, 0, 0, '0, '0, 4'h0, '0, 0, 0, '0));
        valid_last   = 1'b0;

        tbl[0] = mkVec(32'h80000000, 32'h00500293, 1, 5'd5, 0, 32'h0, 32'h00001234, 4'b0000, 32'h0, 0, 1, 32'h00001234);
        tbl[1] = mkVec(32'h80000004, 32'h00002303, 1, 5'd6, 1, 32'hFFFFFF80, 32'h80001000, 4'b0000, 32'h0, 0, 1, 32'hFFFFFF80);
        tbl[2] = mkVec(32'h80000008, 32'h00002003, 1, 5'd0, 1, 32'hFFFFFF80, 32'h80001000, 4'b0000, 32'h0, 0, 0, 32'hFFFFFF80);
        tbl[3] = mkVec(32'h8000000C, 32'h34111073, 0, 5'd0, 0, 32'h0, 32'h0, 4'b0100, 32'h80000010, 0, 0, 32'h0);
        tbl[4] = mkVec(32'h80000010, 32'h008000EF, 1, 5'd1, 0, 32'h0, 32'h80000014, 4'b0000, 32'h0, 1, 1, 32'h80000014);
        tbl[5] = mkVec(32'h80000018, 32'h30529FF3, 1, 5'd31, 0, 32'h0, 32'h00000055, 4'b1010, 32'h000000AB, 0, 1, 32'h00000055);
        tbl[6] = mkVec(32'h8000001C, 32'h00000013, 0, 5'd7, 0, 32'h0, 32'h11111111, 4'b0000, 32'h0, 0, 0, 32'h11111111);
        tbl[7] = mkVec(32'h80000020, 32'h00A00533, 1, 5'd10, 0, 32'h5A5A5A5A, 32'hCAFEBABE, 4'b0000, 32'h0, 0, 1, 32'hCAFEBABE);

        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rst_ready", 64'(ready_last), 64'd1);
        checkOutput("rst_retire", 64'(retire_valid), 64'd0);
        checkOutput("rst_rf_wen", 64'(rf_wen), 64'd0);
        checkOutput("rst_halt", 64'(halt), 64'd0);
        checkOutput("rst_minstret", minstret, 64'd0);
        checkOutput("rst_mstatus", 64'(mstatus), 64'h1800);

        // Back-to-back stream: accept and commit overlap every cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            checkOutput("stream_ready", 64'(ready_last), 64'd1);
            tick();
        end
        valid_last = 1'b0;
        drain("stream_drain");
        checkOutput("stream_minstret", minstret, 64'd8);
        checkOutput("csr_mstatus", 64'(mstatus), 64'h1800);
        checkOutput("csr_mepc", 64'(mepc), 64'h80000010);
        checkOutput("csr_mtvec", 64'(mtvec), 64'hAB);
        checkOutput("csr_mcause", 64'(mcause), 64'hAB);

        // Stall with an empty register still accepts.
        commit_stall = 1'b1;
        checkOutput("stall_empty_ready", 64'(ready_last), 64'd1);
        s = mkVec(32'h80000100, 32'h00C00393, 1, 5'd7, 0, 32'h0, 32'h0000BEEF, 4'b0000, 32'h0, 0, 1, 32'h0000BEEF);
        applyStimulus(s);
        tick();
        valid_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_ready", 64'(ready_last), 64'd0);
            checkOutput("stall_retire", 64'(retire_valid), 64'd0);
            checkOutput("stall_rf_wen", 64'(rf_wen), 64'd0);
            checkOutput("stall_hold_wdata", 64'(rf_wdata), 64'(s.exp_wdata));
            checkOutput("stall_hold_pc", 64'(retire_pc), 64'(s.pc));
            tick();
        end
        commit_stall = 1'b0;
        #1;
        checkOutput("unstall_retire", 64'(retire_valid), 64'd1);
        checkOutput("unstall_ready", 64'(ready_last), 64'd1);
        tick();
        checkOutput("unstall_single", 64'(retire_valid), 64'd0);
        drain("stall_drain");

        // Ebreak retires without an rf write; the following op is swallowed by HALT.
        applyStimulus(mkVec(32'h80000200, EBREAK, 1, 5'd3, 0, 32'h0, 32'h00000999, 4'b0000, 32'h0, 0, 0, 32'h0));
        tick();
        f = mkVec(32'h80000204, 32'h00100093, 1, 5'd1, 0, 32'h0, 32'h00000001, 4'b0000, 32'h0, 0, 1, 32'h1);
        applyStimulus(f);
        checkOutput("ebreak_retire", 64'(retire_valid), 64'd1);
        checkOutput("ebreak_rf_wen", 64'(rf_wen), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("halt_flag", 64'(halt), 64'd1);
            checkOutput("halt_ready", 64'(ready_last), 64'd0);
            checkOutput("halt_retire", 64'(retire_valid), 64'd0);
            tick();
        end
        checkOutput("halt_minstret", minstret, 64'd10);
        valid_last = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("unhalt_halt", 64'(halt), 64'd0);
        checkOutput("unhalt_minstret", minstret, 64'd0);
        checkOutput("unhalt_ready", 64'(ready_last), 64'd1);
        checkOutput("unhalt_retire", 64'(retire_valid), 64'd0);
        applyStimulus(f);
        tick();
        valid_last = 1'b0;
        checkOutput("post_halt_retire", 64'(retire_valid), 64'd1);
        drain("post_halt_drain");

        // Reset while stalled discards the held instruction.
        commit_stall = 1'b1;
        applyStimulus(s);
        tick();
        valid_last = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_stall_retire", 64'(retire_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        commit_stall = 1'b0;
        #1;
        checkOutput("rst_stall_dropped", 64'(retire_valid), 64'd0);
        tick();
        checkOutput("rst_stall_minstret", minstret, 64'd0);
        checkOutput("final_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
